// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arb_pkg
//  Description : Shared types, widths and helpers for the instruction-memory
//                arbiter (grant encoding, bus widths, address range check).
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_arb_pkg;

    localparam int IMEM_ADDR_W  = 16;
    localparam int IMEM_DATA_W  = 32;
    localparam int STARVE_CNT_W = 8;

    // Which requester owns the memory port in the current cycle
    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_LOAD  = 2'd2
    } grant_t;

    // True when a word address falls inside the populated instruction space
    function automatic logic addr_in_range(
        input logic [IMEM_ADDR_W-1:0] addr,
        input int unsigned            max_words
    );
        return ({16'h0000, addr} < max_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arb_starve_ctr
//  Description : Saturating count of consecutive cycles in which the loader
//                requested but was not granted. at_limit flags that the loader
//                must win the next conflict.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_arb_starve_ctr
    import imem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_req,
    input  logic load_gnt,
    output logic at_limit
);

    localparam logic [STARVE_CNT_W-1:0] c_limit = STARVE_CNT_W'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_W-1:0] c_one   = STARVE_CNT_W'(1);

    logic [STARVE_CNT_W-1:0] r_cnt;

    // Count denied load cycles, saturate at the limit, clear on grant or idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load_req && !load_gnt) begin
            if (r_cnt != c_limit) begin
                r_cnt <= r_cnt + c_one;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign at_limit = (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arbiter
//  Description : Arbitrates the single-port instruction memory between the
//                CPU fetch port (fixed priority) and the host load port, with
//                a starvation guard giving the loader a guaranteed slot.
//                Optional macro IMEM_ARB_STATS_EN builds grant statistics
//                counters; otherwise the stat ports read 16'h0000.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned MAX_INSTRUCTIONS = 64,
    parameter int          STARVE_LIMIT     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_req,
    input  logic [IMEM_ADDR_W-1:0] fetch_addr,
    output logic                   fetch_gnt,
    output logic                   fetch_rvalid,
    output logic [IMEM_DATA_W-1:0] fetch_rdata,
    input  logic                   load_req,
    input  logic [IMEM_ADDR_W-1:0] load_addr,
    input  logic [IMEM_DATA_W-1:0] load_wdata,
    output logic                   load_gnt,
    output logic                   load_oob_err,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [IMEM_ADDR_W-1:0] mem_addr,
    output logic [IMEM_DATA_W-1:0] mem_wdata,
    input  logic [IMEM_DATA_W-1:0] mem_rdata,
    output logic [15:0]            stat_fetch_cnt,
    output logic [15:0]            stat_load_cnt
);

    grant_t w_grant;
    logic   w_at_limit;
    logic   w_fetch_in_range;
    logic   w_load_in_range;
    logic   r_fetch_rvalid;
    logic   r_fetch_oob;
    logic   r_load_oob_err;

    assign w_fetch_in_range = addr_in_range(fetch_addr, MAX_INSTRUCTIONS);
    assign w_load_in_range  = addr_in_range(load_addr, MAX_INSTRUCTIONS);

    imem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_req (load_req),
        .load_gnt (load_gnt),
        .at_limit (w_at_limit)
    );

    // Fetch wins conflicts unless the loader has been starved long enough
    always_comb begin
        w_grant = GNT_NONE;
        if (fetch_req && load_req) begin
            w_grant = w_at_limit ? GNT_LOAD : GNT_FETCH;
        end else if (fetch_req) begin
            w_grant = GNT_FETCH;
        end else if (load_req) begin
            w_grant = GNT_LOAD;
        end
    end

    assign fetch_gnt = (w_grant == GNT_FETCH);
    assign load_gnt  = (w_grant == GNT_LOAD);

    // Drive the memory port from the winner; out-of-range accesses are
    // consumed but never strobe the array
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (w_grant)
            GNT_FETCH: begin
                mem_en   = w_fetch_in_range;
                mem_addr = fetch_addr;
            end
            GNT_LOAD: begin
                mem_en    = w_load_in_range;
                mem_we    = w_load_in_range;
                mem_addr  = load_addr;
                mem_wdata = load_wdata;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // Track the read in flight and the sticky out-of-range load flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_rvalid <= 1'b0;
            r_fetch_oob    <= 1'b0;
            r_load_oob_err <= 1'b0;
        end else begin
            r_fetch_rvalid <= fetch_gnt;
            r_fetch_oob    <= fetch_gnt && !w_fetch_in_range;
            if (load_gnt && !w_load_in_range) begin
                r_load_oob_err <= 1'b1;
            end
        end
    end

    assign fetch_rvalid = r_fetch_rvalid;
    assign fetch_rdata  = (r_fetch_rvalid && !r_fetch_oob) ? mem_rdata : '0;
    assign load_oob_err = r_load_oob_err;

`ifdef IMEM_ARB_STATS_EN
    logic [15:0] r_stat_fetch_cnt;
    logic [15:0] r_stat_load_cnt;

    // Free-running grant counters, wrapping at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_fetch_cnt <= '0;
            r_stat_load_cnt  <= '0;
        end else begin
            if (fetch_gnt) begin
                r_stat_fetch_cnt <= r_stat_fetch_cnt + 16'd1;
            end
            if (load_gnt) begin
                r_stat_load_cnt <= r_stat_load_cnt + 16'd1;
            end
        end
    end

    assign stat_fetch_cnt = r_stat_fetch_cnt;
    assign stat_load_cnt  = r_stat_load_cnt;
`else
    assign stat_fetch_cnt = 16'h0000;
    assign stat_load_cnt  = 16'h0000;
`endif

endmodule
`default_nettype wire
